// File: rtl/fetch_port_if.sv
// fetch_port_if: single-outstanding instruction read bus between fetch_port and memory.
// Signals: mem_req/mem_addr (request, held until ack), mem_ack/mem_rdata (completion + data).
// Modports: master = fetch_port side, slave = memory side.
interface fetch_port_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_port.sv
// fetch_port: 2-entry fully associative word buffer feeding fetch_opc/prefetch_opc to the fetch unit.
// Latency: hits are combinational; each miss costs 1 lookup cycle + bus latency + 1 (ack-cycle hit with bypass).
// Backpressure: hold stalls the fetch unit until both words hit; the bus carries one request, held until mem_ack.
// Ports: clk, a_rst (sync, active high); pc_in/pf_in lookup addresses (bit 0 ignored); flush drops both entries;
//        fetch_opc/prefetch_opc/hold to the fetch unit; bus (fetch_port_if.master) to memory.
// Option: define FETCH_PORT_BYPASS_EN to forward mem_rdata in the ack cycle and chain the second fill directly.
module fetch_port (
  input  logic         clk,
  input  logic         a_rst,
  input  logic [15:0]  pc_in,
  input  logic [15:0]  pf_in,
  input  logic         flush,
  output logic [15:0]  fetch_opc,
  output logic [15:0]  prefetch_opc,
  output logic         hold,
  fetch_port_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD_PC, RD_PF} state_t;

  state_t           state, state_nxt;
  logic [1:0]       valid, valid_nxt;
  logic [1:0][14:0] tag, tag_nxt;
  logic [1:0][15:0] data, data_nxt;
  logic             req_q, req_nxt;
  logic [15:0]      addr_q, addr_nxt;
  logic [14:0]      req_tag, req_tag_nxt;
  logic             victim, victim_nxt;
  logic             flush_pend, flush_pend_nxt;

  logic [14:0] pc_tag, pf_tag;
  logic [1:0]  m_pc, m_pf;
  logic        hit_pc, hit_pf;
  logic        fill_live;
  logic        bp_pc, bp_pf;

  assign pc_tag = pc_in[15:1];
  assign pf_tag = pf_in[15:1];

  assign m_pc[0] = valid[0] && (tag[0] == pc_tag);
  assign m_pc[1] = valid[1] && (tag[1] == pc_tag);
  assign m_pf[0] = valid[0] && (tag[0] == pf_tag);
  assign m_pf[1] = valid[1] && (tag[1] == pf_tag);
  assign hit_pc  = |m_pc;
  assign hit_pf  = |m_pf;

  // A completing fill whose data will actually be written (not killed by a flush).
  assign fill_live = (state != IDLE) && bus.mem_ack && !flush_pend && !flush;

`ifdef FETCH_PORT_BYPASS_EN
  assign bp_pc = fill_live && (req_tag == pc_tag);
  assign bp_pf = fill_live && (req_tag == pf_tag);
`else
  assign bp_pc = 1'b0;
  assign bp_pf = 1'b0;
`endif

  // Entry 0 wins on a double match.
  always_comb begin
    fetch_opc = 16'h0000;
    if (hit_pc)     fetch_opc = m_pc[0] ? data[0] : data[1];
    else if (bp_pc) fetch_opc = bus.mem_rdata;
  end

  always_comb begin
    prefetch_opc = 16'h0000;
    if (hit_pf)     prefetch_opc = m_pf[0] ? data[0] : data[1];
    else if (bp_pf) prefetch_opc = bus.mem_rdata;
  end

  assign hold = ~((hit_pc | bp_pc) & (hit_pf | bp_pf));

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;

  // Pick the entry that does not hold the other word we still need; dflt when neither does.
  function automatic logic pick_victim(input logic [1:0] keep, input logic dflt);
    if (keep[0])      return 1'b1;
    else if (keep[1]) return 1'b0;
    else              return dflt;
  endfunction

`ifdef FETCH_PORT_BYPASS_EN
  // Hit status as it will be after the current fill is written into the victim slot.
  logic pc_after, pf_after;
  assign pc_after = bp_pc || m_pc[~victim];
  assign pf_after = bp_pf || m_pf[~victim];
`endif

  always_comb begin
    state_nxt      = state;
    valid_nxt      = valid;
    tag_nxt        = tag;
    data_nxt       = data;
    req_nxt        = req_q;
    addr_nxt       = addr_q;
    req_tag_nxt    = req_tag;
    victim_nxt     = victim;
    flush_pend_nxt = flush_pend;

    if (flush) valid_nxt = 2'b00;

    case (state)
      IDLE: begin
        if (!hit_pc) begin
          state_nxt   = RD_PC;
          req_nxt     = 1'b1;
          addr_nxt    = {pc_tag, 1'b0};
          req_tag_nxt = pc_tag;
          victim_nxt  = pick_victim(m_pf, 1'b0);
        end else if (!hit_pf) begin
          state_nxt   = RD_PF;
          req_nxt     = 1'b1;
          addr_nxt    = {pf_tag, 1'b0};
          req_tag_nxt = pf_tag;
          victim_nxt  = pick_victim(m_pc, 1'b1);
        end
      end
      RD_PC, RD_PF: begin
        // A flush mid-transfer lets the bus cycle finish but poisons its write.
        if (flush) flush_pend_nxt = 1'b1;
        if (bus.mem_ack) begin
          state_nxt      = IDLE;
          req_nxt        = 1'b0;
          flush_pend_nxt = 1'b0;
          if (fill_live) begin
            valid_nxt[victim] = 1'b1;
            tag_nxt[victim]   = req_tag;
            data_nxt[victim]  = bus.mem_rdata;
`ifdef FETCH_PORT_BYPASS_EN
            // Skip the lookup cycle: go straight to the prefetch fill when it is the only miss left.
            if (pc_after && !pf_after) begin
              state_nxt   = RD_PF;
              req_nxt     = 1'b1;
              addr_nxt    = {pf_tag, 1'b0};
              req_tag_nxt = pf_tag;
              victim_nxt  = bp_pc ? ~victim : victim;
            end
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state      <= IDLE;
      valid      <= 2'b00;
      tag        <= '0;
      data       <= '0;
      req_q      <= 1'b0;
      addr_q     <= 16'h0000;
      req_tag    <= 15'h0000;
      victim     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid      <= valid_nxt;
      tag        <= tag_nxt;
      data       <= data_nxt;
      req_q      <= req_nxt;
      addr_q     <= addr_nxt;
      req_tag    <= req_tag_nxt;
      victim     <= victim_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_port.sv
// tb_fetch_port: directed scenarios for fetch_port with a scoreboard of expected bus reads.
// A memory responder with programmable ack latency answers requests; a monitor pops expected
// addresses on each completed read and checks address stability while a request is pending.
module tb_fetch_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst;
  logic [15:0] pc_in, pf_in;
  logic        flush;
  logic [15:0] fetch_opc, prefetch_opc;
  logic        hold;

  fetch_port_if bus();

  fetch_port dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .pc_in        (pc_in),
    .pf_in        (pf_in),
    .flush        (flush),
    .fetch_opc    (fetch_opc),
    .prefetch_opc (prefetch_opc),
    .hold         (hold),
    .bus          (bus)
  );

`ifdef FETCH_PORT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_rd[$];

  int          lat        = 0;
  int          wait_cnt   = 0;
  logic        resp_ack   = 1'b0;
  logic [15:0] resp_rdata = 16'h0000;
  logic        late_ack   = 1'b0;

  assign bus.mem_ack   = resp_ack | late_ack;
  assign bus.mem_rdata = late_ack ? 16'hBEEF : resp_rdata;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h8000: return 16'hA000;
      16'h8002: return 16'hA002;
      16'hFFFE: return 16'hFFEE;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // Memory: acks after 'lat' wait cycles; lat = 0 acks in the first request cycle.
  always @(posedge clk) begin
    #1;
    if (resp_ack) wait_cnt = 0;
    if (bus.mem_req && !a_rst) begin
      if (wait_cnt >= lat) begin
        resp_ack   = 1'b1;
        resp_rdata = mem_word(bus.mem_addr);
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: completed reads against the scoreboard, address held while pending.
  logic        prev_pend = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  always @(negedge clk) begin
    if (!a_rst && bus.mem_req) begin
      if (prev_pend) check16("addr_stable", bus.mem_addr, prev_addr);
      if (bus.mem_ack) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: got read at %h, required no read", bus.mem_addr);
        end else begin
          check16("rd_addr", bus.mem_addr, exp_rd.pop_front());
        end
      end
    end
    prev_pend = !a_rst && bus.mem_req && !bus.mem_ack;
    prev_addr = bus.mem_addr;
  end

  // Apply pc/pf at cycle 0 (also releases reset), pulse flush at cycle flush_at,
  // return the first cycle with hold low (-1 if the budget expires) and fetch_opc at cycle 0.
  task automatic run_fill(input logic [15:0] pc, input logic [15:0] pf, input int flush_at,
                          input int budget, output int cyc, output logic [15:0] f0);
    cyc = -1;
    f0  = 16'h0000;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (c == 0) begin
        pc_in = pc;
        pf_in = pf;
        a_rst = 1'b0;
      end
      flush = (c == flush_at);
      @(negedge clk);
      if (c == 0) f0 = fetch_opc;
      if (!hold) begin
        cyc = c;
        break;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    logic [15:0] f0;

    a_rst = 1'b1;
    pc_in = 16'h0000;
    pf_in = 16'h0002;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check16("rst_hold",     {15'd0, hold},        16'd1);
    check16("rst_fetch",    fetch_opc,            16'h0000);
    check16("rst_prefetch", prefetch_opc,         16'h0000);
    check16("rst_req",      {15'd0, bus.mem_req}, 16'd0);
    check16("rst_addr",     bus.mem_addr,         16'h0000);

    // Cold double miss, zero-wait memory.
    lat = 0;
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0002);
    run_fill(16'h0000, 16'h0002, -1, 40, cyc, f0);
    check_int("t1_hold_low_cycle", cyc, BYP ? 2 : 4);
    check16("t1_fetch",    fetch_opc,    16'h1111);
    check16("t1_prefetch", prefetch_opc, 16'h2222);
    #1 check_int("t1_reads_left", exp_rd.size(), 0);

    // Sequential step: only the new prefetch word is read.
    exp_rd.push_back(16'h0004);
    run_fill(16'h0002, 16'h0004, -1, 40, cyc, f0);
    check16("t2_fetch_at_c0", f0, 16'h2222);
    check_int("t2_hold_low_cycle", cyc, BYP ? 1 : 2);
    check16("t2_fetch",    fetch_opc,    16'h2222);
    check16("t2_prefetch", prefetch_opc, 16'h3333);
    #1 check_int("t2_reads_left", exp_rd.size(), 0);

    // Branch with 3-cycle ack latency.
    lat = 3;
    exp_rd.push_back(16'h8000);
    exp_rd.push_back(16'h8002);
    run_fill(16'h8000, 16'h8002, -1, 40, cyc, f0);
    check_int("t3_hold_low_cycle", cyc, BYP ? 8 : 10);
    check16("t3_fetch",    fetch_opc,    16'hA000);
    check16("t3_prefetch", prefetch_opc, 16'hA002);
    #1 check_int("t3_reads_left", exp_rd.size(), 0);

    // Flush during the pc read: that read is discarded and redone, then pf refilled.
    exp_rd.push_back(16'h0010);
    exp_rd.push_back(16'h0010);
    exp_rd.push_back(16'h8002);
    run_fill(16'h0010, 16'h8002, 2, 40, cyc, f0);
    check_int("t4_hold_low_cycle", cyc, BYP ? 13 : 15);
    check16("t4_fetch",    fetch_opc,    16'h5A4A);
    check16("t4_prefetch", prefetch_opc, 16'hA002);
    #1 check_int("t4_reads_left", exp_rd.size(), 0);

    // Address wrap: 0xFFFE and 0x0000 occupy distinct entries.
    lat = 0;
    exp_rd.push_back(16'hFFFE);
    exp_rd.push_back(16'h0000);
    run_fill(16'hFFFE, 16'h0000, -1, 40, cyc, f0);
    check_int("t5_hold_low_cycle", cyc, BYP ? 2 : 4);
    check16("t5_fetch",    fetch_opc,    16'hFFEE);
    check16("t5_prefetch", prefetch_opc, 16'h1111);
    #1 check_int("t5_reads_left", exp_rd.size(), 0);

    // Reset with a request in flight, then a stray ack in IDLE.
    lat = 3;
    @(posedge clk); #2;
    pc_in = 16'h0020;
    pf_in = 16'h0000;
    @(negedge clk);
    @(posedge clk); #2;
    @(negedge clk);
    check16("t6_req_up",   {15'd0, bus.mem_req}, 16'd1);
    check16("t6_req_addr", bus.mem_addr,         16'h0020);
    @(posedge clk); #2;
    a_rst = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check16("t6_rst_req",  {15'd0, bus.mem_req}, 16'd0);
    check16("t6_rst_hold", {15'd0, hold},        16'd1);
    check16("t6_rst_addr", bus.mem_addr,         16'h0000);
    exp_rd.push_back(16'h0020);
    exp_rd.push_back(16'h0000);
    @(posedge clk); #2;
    a_rst    = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    check16("t6_idle_hold", {15'd0, hold}, 16'd1);
    @(posedge clk); #2;
    late_ack = 1'b0;
    @(negedge clk);
    check16("t6_no_stray_write", fetch_opc,     16'h0000);
    check16("t6_refetch_hold",   {15'd0, hold}, 16'd1);
    run_fill(16'h0020, 16'h0000, -1, 40, cyc, f0);
    check_int("t6_refilled", (cyc >= 0) ? 1 : 0, 1);
    check16("t6_fetch",    fetch_opc,    16'h5A7A);
    check16("t6_prefetch", prefetch_opc, 16'h1111);
    #1 check_int("t6_reads_left", exp_rd.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
